// File: rtl/alu_rs.sv
// alu_rs: reservation station for ALU-class instructions.
// Optional RS_STATS_EN adds dispatch and full-cycle counters.
module alu_rs #(
  parameter int RS_SIZE   = 16,
  parameter int ROB_POS_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rollback,
  input  logic                 issue_en,
  input  logic [6:0]           issue_opcode,
  input  logic [2:0]           issue_funct3,
  input  logic                 issue_funct7,
  input  logic [31:0]          issue_rs1_val,
  input  logic [ROB_POS_W:0]   issue_rs1_tag,
  input  logic [31:0]          issue_rs2_val,
  input  logic [ROB_POS_W:0]   issue_rs2_tag,
  input  logic [31:0]          issue_imm,
  input  logic [31:0]          issue_pc,
  input  logic [ROB_POS_W-1:0] issue_rob_pos,
  output logic                 rs_full,
  input  logic                 alu_result,
  input  logic [ROB_POS_W-1:0] alu_result_rob_pos,
  input  logic [31:0]          alu_result_val,
  input  logic                 lsb_result,
  input  logic [ROB_POS_W-1:0] lsb_result_rob_pos,
  input  logic [31:0]          lsb_result_val,
  output logic                 alu_en,
  output logic [6:0]           alu_opcode,
  output logic [2:0]           alu_funct3,
  output logic                 alu_funct7,
  output logic [31:0]          alu_val1,
  output logic [31:0]          alu_val2,
  output logic [31:0]          alu_imm,
  output logic [31:0]          alu_pc,
`ifdef RS_STATS_EN
  output logic [31:0]          stat_dispatch_cnt,
  output logic [31:0]          stat_full_cycles,
`endif
  output logic [ROB_POS_W-1:0] alu_rob_pos
);

  localparam int IW = $clog2(RS_SIZE);
  localparam int RW = ROB_POS_W;

  typedef struct packed {
    logic          busy;
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic          funct7;
    logic          p1;
    logic [RW-1:0] t1;
    logic [31:0]   v1;
    logic          p2;
    logic [RW-1:0] t2;
    logic [31:0]   v2;
    logic [31:0]   imm;
    logic [31:0]   pc;
    logic [RW-1:0] rob;
  } ent_t;

  ent_t          ent [RS_SIZE];
  ent_t          new_ent;
  logic [IW-1:0] free_idx;
  logic [IW-1:0] sel_idx;
  logic          free_ok;
  logic          sel_ok;

  // Resolve a pending operand against both broadcasts; ALU wins.
  function automatic logic [32:0] snoop(
    input logic          p,
    input logic [RW-1:0] t,
    input logic [31:0]   v
  );
    logic [32:0] r;
    r = {p, v};
    if (p && alu_result && alu_result_rob_pos == t)
      r = {1'b0, alu_result_val};
    else if (p && lsb_result && lsb_result_rob_pos == t)
      r = {1'b0, lsb_result_val};
    return r;
  endfunction

  // Lowest free slot for issue, lowest ready slot for dispatch.
  always_comb begin
    free_ok  = 1'b0;
    free_idx = '0;
    sel_ok   = 1'b0;
    sel_idx  = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!ent[i].busy) begin
        free_ok  = 1'b1;
        free_idx = IW'(i);
      end
      if (ent[i].busy && !ent[i].p1 && !ent[i].p2) begin
        sel_ok  = 1'b1;
        sel_idx = IW'(i);
      end
    end
  end

  assign rs_full = !free_ok;

  // Incoming entry with same-cycle broadcast capture.
  always_comb begin
    new_ent        = '0;
    new_ent.busy   = 1'b1;
    new_ent.opcode = issue_opcode;
    new_ent.funct3 = issue_funct3;
    new_ent.funct7 = issue_funct7;
    new_ent.t1     = issue_rs1_tag[RW-1:0];
    new_ent.t2     = issue_rs2_tag[RW-1:0];
    {new_ent.p1, new_ent.v1} =
      snoop(issue_rs1_tag[RW], issue_rs1_tag[RW-1:0], issue_rs1_val);
    {new_ent.p2, new_ent.v2} =
      snoop(issue_rs2_tag[RW], issue_rs2_tag[RW-1:0], issue_rs2_val);
    new_ent.imm    = issue_imm;
    new_ent.pc     = issue_pc;
    new_ent.rob    = issue_rob_pos;
  end

  // Entry state: wakeup, dispatch, issue; flushed by rst or rollback.
  always_ff @(posedge clk) begin
    if (rst || rollback) begin
      for (int i = 0; i < RS_SIZE; i++) ent[i].busy <= 1'b0;
    end else if (rdy) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (ent[i].busy) begin
          {ent[i].p1, ent[i].v1} <= snoop(ent[i].p1, ent[i].t1, ent[i].v1);
          {ent[i].p2, ent[i].v2} <= snoop(ent[i].p2, ent[i].t2, ent[i].v2);
        end
      end
      if (sel_ok) ent[sel_idx].busy <= 1'b0;
      if (issue_en && free_ok) ent[free_idx] <= new_ent;
    end
  end

  // Dispatch registers toward the ALU.
  always_ff @(posedge clk) begin
    if (rst || rollback) begin
      alu_en      <= 1'b0;
      alu_opcode  <= '0;
      alu_funct3  <= '0;
      alu_funct7  <= 1'b0;
      alu_val1    <= '0;
      alu_val2    <= '0;
      alu_imm     <= '0;
      alu_pc      <= '0;
      alu_rob_pos <= '0;
    end else if (rdy) begin
      alu_en <= sel_ok;
      if (sel_ok) begin
        alu_opcode  <= ent[sel_idx].opcode;
        alu_funct3  <= ent[sel_idx].funct3;
        alu_funct7  <= ent[sel_idx].funct7;
        alu_val1    <= ent[sel_idx].v1;
        alu_val2    <= ent[sel_idx].v2;
        alu_imm     <= ent[sel_idx].imm;
        alu_pc      <= ent[sel_idx].pc;
        alu_rob_pos <= ent[sel_idx].rob;
      end
    end
  end

`ifdef RS_STATS_EN
  // Counters survive rollback; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_dispatch_cnt <= '0;
      stat_full_cycles  <= '0;
    end else if (rdy) begin
      if (sel_ok && !rollback)
        stat_dispatch_cnt <= stat_dispatch_cnt + 32'd1;
      if (rs_full)
        stat_full_cycles <= stat_full_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed vector table plus multi-cycle sequences
// for the alu_rs reservation station.
module tb_alu_rs;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback, issue_en;
  logic [6:0]  issue_opcode;
  logic [2:0]  issue_funct3;
  logic        issue_funct7;
  logic [31:0] issue_rs1_val, issue_rs2_val, issue_imm, issue_pc;
  logic [4:0]  issue_rs1_tag, issue_rs2_tag;
  logic [3:0]  issue_rob_pos;
  logic        rs_full;
  logic        alu_result, lsb_result;
  logic [3:0]  alu_result_rob_pos, lsb_result_rob_pos;
  logic [31:0] alu_result_val, lsb_result_val;
  logic        alu_en;
  logic [6:0]  alu_opcode;
  logic [2:0]  alu_funct3;
  logic        alu_funct7;
  logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;
  logic [3:0]  alu_rob_pos;
`ifdef RS_STATS_EN
  logic [31:0] stat_dispatch_cnt, stat_full_cycles;
`endif

  int passed = 0;
  int total  = 0;

  alu_rs dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .issue_en(issue_en), .issue_opcode(issue_opcode),
    .issue_funct3(issue_funct3), .issue_funct7(issue_funct7),
    .issue_rs1_val(issue_rs1_val), .issue_rs1_tag(issue_rs1_tag),
    .issue_rs2_val(issue_rs2_val), .issue_rs2_tag(issue_rs2_tag),
    .issue_imm(issue_imm), .issue_pc(issue_pc),
    .issue_rob_pos(issue_rob_pos), .rs_full(rs_full),
    .alu_result(alu_result), .alu_result_rob_pos(alu_result_rob_pos),
    .alu_result_val(alu_result_val),
    .lsb_result(lsb_result), .lsb_result_rob_pos(lsb_result_rob_pos),
    .lsb_result_val(lsb_result_val),
    .alu_en(alu_en), .alu_opcode(alu_opcode), .alu_funct3(alu_funct3),
    .alu_funct7(alu_funct7), .alu_val1(alu_val1), .alu_val2(alu_val2),
    .alu_imm(alu_imm), .alu_pc(alu_pc),
`ifdef RS_STATS_EN
    .stat_dispatch_cnt(stat_dispatch_cnt),
    .stat_full_cycles(stat_full_cycles),
`endif
    .alu_rob_pos(alu_rob_pos)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] v1;
    logic [4:0]  t1;
    logic [31:0] v2;
    logic [4:0]  t2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [3:0]  rob;
    logic        ab;
    logic [3:0]  ar;
    logic [31:0] av;
    logic        lb;
    logic [3:0]  lr;
    logic [31:0] lv;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vt [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h required %h", nm, act, exp);
    else
      passed++;
  endtask

  task automatic clr();
    issue_en   = 1'b0;
    alu_result = 1'b0;
    lsb_result = 1'b0;
  endtask

  task automatic iss(input logic [6:0] op, input logic [31:0] v1,
                     input logic [4:0] t1, input logic [31:0] v2,
                     input logic [4:0] t2, input logic [3:0] rob);
    issue_en      = 1'b1;
    issue_opcode  = op;
    issue_funct3  = 3'd0;
    issue_funct7  = 1'b0;
    issue_rs1_val = v1;
    issue_rs1_tag = t1;
    issue_rs2_val = v2;
    issue_rs2_tag = t2;
    issue_imm     = 32'd0;
    issue_pc      = 32'd0;
    issue_rob_pos = rob;
  endtask

  task automatic abc(input logic [3:0] r, input logic [31:0] v);
    alu_result         = 1'b1;
    alu_result_rob_pos = r;
    alu_result_val     = v;
  endtask

  task automatic lbc(input logic [3:0] r, input logic [31:0] v);
    lsb_result         = 1'b1;
    lsb_result_rob_pos = r;
    lsb_result_val     = v;
  endtask

  // Later broadcast on pending rs2 (tag 9); expect given value.
  task automatic wake_test(input string nm, input logic a,
                           input logic l, input logic [31:0] exp);
    iss(7'h63, 32'h3, 5'd0, 32'h0, 5'b1_1001, 4'd8);
    tick();
    clr();
    tick();
    chk({nm, "_early"}, alu_en, 0);
    if (a) abc(4'd9, 32'hA1);
    if (l) lbc(4'd9, 32'hB2);
    tick();
    clr();
    chk({nm, "_m1"}, alu_en, 0);
    tick();
    chk({nm, "_en"}, alu_en, 1);
    chk({nm, "_v2"}, alu_val2, exp);
    tick();
    chk({nm, "_en_off"}, alu_en, 0);
  endtask

  initial begin
    vt[0] = '{7'h33, 3'd0, 1'b0, 32'd5, 5'd0, 32'd7, 5'd0,
              32'd0, 32'h1000, 4'd3,
              1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd5, 32'd7};
    vt[1] = '{7'h33, 3'd0, 1'b1, 32'd100, 5'd0, 32'd30, 5'd0,
              32'd0, 32'h1004, 4'd4,
              1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd100, 32'd30};
    vt[2] = '{7'h13, 3'd5, 1'b1, 32'd0, 5'b1_0110, 32'd0, 5'd0,
              32'hFFFF_FFF0, 32'h1008, 4'd5,
              1'b1, 4'd6, 32'h1234, 1'b1, 4'd6, 32'hDEAD,
              32'h1234, 32'd0};
    vt[3] = '{7'h63, 3'd1, 1'b0, 32'hA, 5'd0, 32'd0, 5'b1_0110,
              32'd8, 32'h100C, 4'd6,
              1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 32'h99, 32'hA, 32'h99};
    vt[4] = '{7'h37, 3'd0, 1'b0, 32'd0, 5'd0, 32'd0, 5'd0,
              32'h1234_5000, 32'h100, 4'd15,
              1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0};
    vt[5] = '{7'h67, 3'd0, 1'b0, 32'd0, 5'b1_0001, 32'd0, 5'b1_0010,
              32'd4, 32'h2000, 4'd7,
              1'b1, 4'd1, 32'h77, 1'b1, 4'd2, 32'h88, 32'h77, 32'h88};
    vt[6] = '{7'h33, 3'd7, 1'b0, 32'h11, 5'b0_0011, 32'h22, 5'd0,
              32'd0, 32'h2004, 4'd0,
              1'b1, 4'd3, 32'hBAD, 1'b0, 4'd0, 32'd0, 32'h11, 32'h22};

    rst = 1'b1; rdy = 1'b0; rollback = 1'b0;
    clr();
    iss(7'h33, 32'd1, 5'd0, 32'd1, 5'd0, 4'd1);
    issue_en = 1'b1;
    alu_result_rob_pos = '0; alu_result_val = '0;
    lsb_result_rob_pos = '0; lsb_result_val = '0;
    tick();
    tick();
    rst = 1'b0; rdy = 1'b1;
    clr();
    chk("rst_en", alu_en, 0);
    chk("rst_full", rs_full, 0);
    chk("rst_val1", alu_val1, 0);
    chk("rst_rob", alu_rob_pos, 0);
    tick();
    chk("rst_no_issue", alu_en, 0);

    for (int k = 0; k < 7; k++) begin
      iss(vt[k].op, vt[k].v1, vt[k].t1, vt[k].v2, vt[k].t2, vt[k].rob);
      issue_funct3 = vt[k].f3;
      issue_funct7 = vt[k].f7;
      issue_imm    = vt[k].imm;
      issue_pc     = vt[k].pc;
      if (vt[k].ab) abc(vt[k].ar, vt[k].av);
      if (vt[k].lb) lbc(vt[k].lr, vt[k].lv);
      tick();
      clr();
      chk($sformatf("v%0d_en_n1", k), alu_en, 0);
      tick();
      chk($sformatf("v%0d_en", k), alu_en, 1);
      chk($sformatf("v%0d_op", k), alu_opcode, vt[k].op);
      chk($sformatf("v%0d_f3", k), alu_funct3, vt[k].f3);
      chk($sformatf("v%0d_f7", k), alu_funct7, vt[k].f7);
      chk($sformatf("v%0d_v1", k), alu_val1, vt[k].e1);
      chk($sformatf("v%0d_v2", k), alu_val2, vt[k].e2);
      chk($sformatf("v%0d_imm", k), alu_imm, vt[k].imm);
      chk($sformatf("v%0d_pc", k), alu_pc, vt[k].pc);
      chk($sformatf("v%0d_rob", k), alu_rob_pos, vt[k].rob);
      tick();
      chk($sformatf("v%0d_en_n3", k), alu_en, 0);
    end

    iss(7'h33, 32'h0, 5'b1_0010, 32'd3, 5'd0, 4'd11);
    tick();
    clr();
    chk("wk_n1", alu_en, 0);
    tick();
    chk("wk_n2", alu_en, 0);
    abc(4'd2, 32'h55);
    tick();
    clr();
    chk("wk_m1", alu_en, 0);
    tick();
    chk("wk_en", alu_en, 1);
    chk("wk_v1", alu_val1, 32'h55);
    chk("wk_v2", alu_val2, 32'd3);
    chk("wk_rob", alu_rob_pos, 11);
    tick();
    chk("wk_off", alu_en, 0);

    wake_test("wk_pri", 1'b1, 1'b1, 32'hA1);
    wake_test("wk_lsb", 1'b0, 1'b1, 32'hB2);

    for (int k = 0; k < 16; k++) begin
      if (k == 15) chk("fill_not_full", rs_full, 0);
      iss(7'h33, 32'h0, {1'b1, 4'(k)}, 32'd1, 5'd0, 4'(k));
      tick();
    end
    clr();
    chk("fill_full", rs_full, 1);
    chk("fill_en", alu_en, 0);
    abc(4'd0, 32'hE0);
    tick();
    clr();
    chk("fill_m1_full", rs_full, 1);
    chk("fill_m1_en", alu_en, 0);
    tick();
    chk("e0_en", alu_en, 1);
    chk("e0_rob", alu_rob_pos, 0);
    chk("e0_v1", alu_val1, 32'hE0);
    chk("e0_full", rs_full, 0);
    iss(7'h33, 32'hC0, 5'd0, 32'd2, 5'd0, 4'd12);
    abc(4'd3, 32'h33);
    lbc(4'd1, 32'h11);
    tick();
    clr();
    chk("reuse_full", rs_full, 1);
    chk("reuse_en", alu_en, 0);
    tick();
    chk("reuse_d_rob", alu_rob_pos, 12);
    chk("reuse_d_v1", alu_val1, 32'hC0);
    tick();
    chk("e1_en", alu_en, 1);
    chk("e1_rob", alu_rob_pos, 1);
    chk("e1_v1", alu_val1, 32'h11);
    tick();
    chk("e3_rob", alu_rob_pos, 3);
    chk("e3_v1", alu_val1, 32'h33);
    tick();
    chk("e3_off", alu_en, 0);

    abc(4'd2, 32'h22);
    tick();
    clr();
    rollback = 1'b1;
    iss(7'h33, 32'h5, 5'd0, 32'h6, 5'd0, 4'd5);
    tick();
    rollback = 1'b0;
    clr();
    chk("rb_full", rs_full, 0);
    chk("rb_en", alu_en, 0);
    chk("rb_v1", alu_val1, 0);
    chk("rb_rob", alu_rob_pos, 0);
    tick();
    chk("rb_en2", alu_en, 0);
    abc(4'd4, 32'h4);
    lbc(4'd5, 32'h5);
    tick();
    clr();
    tick();
    chk("rb_stale", alu_en, 0);
    chk("rb_full2", rs_full, 0);

    iss(7'h33, 32'h5A, 5'd0, 32'hA5, 5'd0, 4'd9);
    tick();
    clr();
    tick();
    chk("fz_en", alu_en, 1);
    rdy = 1'b0;
    iss(7'h33, 32'h66, 5'd0, 32'h1, 5'd0, 4'd10);
    abc(4'd9, 32'hFF);
    tick();
    tick();
    tick();
    chk("fz_hold_en", alu_en, 1);
    chk("fz_hold_v1", alu_val1, 32'h5A);
    chk("fz_hold_v2", alu_val2, 32'hA5);
    chk("fz_hold_rob", alu_rob_pos, 9);
    chk("fz_full", rs_full, 0);
    rdy = 1'b1;
    clr();
    tick();
    chk("fz_no_dup", alu_en, 0);
    tick();
    chk("fz_no_issue", alu_en, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
